// File: rtl/vx_split_join_ctrl_if.sv
// Scheduler/stack-facing signal bundle of the split/join divergence controller.
// master = scheduler + IPDOM stack side, slave = the controller itself.
interface vx_split_join_ctrl_if #(
    parameter int NUM_THREADS = 4,
    parameter int PC_W        = 32
);
    localparam int STK_W = NUM_THREADS + PC_W;

    logic                   req_valid_i;
    logic                   req_ready_o;
    logic                   req_is_join_i;
    logic [NUM_THREADS-1:0] req_tmask_i;
    logic [NUM_THREADS-1:0] req_pred_i;
    logic [PC_W-1:0]        req_else_pc_i;

    logic                   stk_push_o;
    logic                   stk_pop_o;
    logic                   stk_pair_o;
    logic [STK_W-1:0]       stk_q1_o;
    logic [STK_W-1:0]       stk_q2_o;
    logic [STK_W-1:0]       stk_d_i;
    logic                   stk_index_i;
    logic                   stk_empty_i;
    logic                   stk_full_i;

    logic                   upd_valid_o;
    logic [NUM_THREADS-1:0] upd_tmask_o;
    logic                   upd_pc_valid_o;
    logic [PC_W-1:0]        upd_pc_o;
    logic                   err_ovf_o;
    logic                   err_unf_o;

    modport master (
        output req_valid_i, req_is_join_i, req_tmask_i, req_pred_i, req_else_pc_i,
        output stk_d_i, stk_index_i, stk_empty_i, stk_full_i,
        input  req_ready_o, stk_push_o, stk_pop_o, stk_pair_o, stk_q1_o, stk_q2_o,
        input  upd_valid_o, upd_tmask_o, upd_pc_valid_o, upd_pc_o, err_ovf_o, err_unf_o
    );

    modport slave (
        input  req_valid_i, req_is_join_i, req_tmask_i, req_pred_i, req_else_pc_i,
        input  stk_d_i, stk_index_i, stk_empty_i, stk_full_i,
        output req_ready_o, stk_push_o, stk_pop_o, stk_pair_o, stk_q1_o, stk_q2_o,
        output upd_valid_o, upd_tmask_o, upd_pc_valid_o, upd_pc_o, err_ovf_o, err_unf_o
    );
endinterface

// File: rtl/vx_split_join_ctrl.sv
// Per-warp split/join controller: turns scheduler divergence requests into IPDOM
// stack push/pop traffic and returns the resulting thread mask / PC.
//
//  state  | meaning
//  S_IDLE | ready for a request; accept registers the request fields
//  S_PUSH | split: push strobe (or overflow), result computed
//  S_POP  | join: pop strobe (or underflow), stack top sampled pre-pop
//  S_RESP | one-cycle upd_valid pulse to the scheduler
module vx_split_join_ctrl #(
    parameter int NUM_THREADS = 4,
    parameter int PC_W        = 32
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    vx_split_join_ctrl_if.slave bus
);
    localparam int STK_W = NUM_THREADS + PC_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PUSH = 2'd1,
        S_POP  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_accept;

    logic [NUM_THREADS-1:0] r_tmask;
    logic [NUM_THREADS-1:0] r_pred;
    logic [PC_W-1:0]        r_else_pc;

    logic [NUM_THREADS-1:0] w_taken;
    logic [NUM_THREADS-1:0] w_els;
    logic                   w_div;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_pair;
    logic [STK_W-1:0]       w_q1;
    logic [STK_W-1:0]       w_q2;

    logic [NUM_THREADS-1:0] r_upd_tmask;
    logic [NUM_THREADS-1:0] w_upd_tmask;
    logic                   r_upd_pc_valid;
    logic                   w_upd_pc_valid;
    logic [PC_W-1:0]        r_upd_pc;
    logic [PC_W-1:0]        w_upd_pc;

    logic                   r_err_ovf;
    logic                   r_err_unf;
    logic                   w_set_ovf;
    logic                   w_set_unf;

    assign w_accept = (r_state == S_IDLE) && bus.req_valid_i;
    assign w_taken  = r_tmask & r_pred;
    assign w_els    = r_tmask & ~r_pred;
    assign w_div    = (|w_taken) && (|w_els);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Strobes are decoded straight from state so an async reset drops them in the same cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_push         = 1'b0;
        w_pop          = 1'b0;
        w_pair         = 1'b0;
        w_q1           = '0;
        w_q2           = '0;
        w_upd_tmask    = r_upd_tmask;
        w_upd_pc_valid = r_upd_pc_valid;
        w_upd_pc       = r_upd_pc;
        w_set_ovf      = 1'b0;
        w_set_unf      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid_i) begin
                    w_state_nxt = bus.req_is_join_i ? S_POP : S_PUSH;
                end
            end
            S_PUSH: begin
                w_state_nxt    = S_RESP;
                w_upd_pc_valid = 1'b0;
                w_upd_pc       = '0;
                if (bus.stk_full_i) begin
                    w_set_ovf   = 1'b1;
                    w_upd_tmask = r_tmask;
                end else begin
                    w_push      = 1'b1;
                    w_pair      = w_div;
                    w_q1        = {r_tmask, {PC_W{1'b0}}};
                    w_q2        = w_div ? {w_els, r_else_pc} : '0;
                    w_upd_tmask = w_div ? w_taken : r_tmask;
                end
            end
            S_POP: begin
                w_state_nxt = S_RESP;
                if (bus.stk_empty_i) begin
                    w_set_unf      = 1'b1;
                    w_upd_tmask    = r_tmask;
                    w_upd_pc_valid = 1'b0;
                    w_upd_pc       = '0;
                end else begin
                    w_pop          = 1'b1;
                    w_upd_tmask    = bus.stk_d_i[STK_W-1:PC_W];
                    w_upd_pc       = bus.stk_d_i[PC_W-1:0];
                    w_upd_pc_valid = ~bus.stk_index_i;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tmask   <= '0;
            r_pred    <= '0;
            r_else_pc <= '0;
        end else if (w_accept) begin
            r_tmask   <= bus.req_tmask_i;
            r_pred    <= bus.req_pred_i;
            r_else_pc <= bus.req_else_pc_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_upd_tmask    <= '0;
            r_upd_pc_valid <= 1'b0;
            r_upd_pc       <= '0;
            r_err_ovf      <= 1'b0;
            r_err_unf      <= 1'b0;
        end else begin
            r_upd_tmask    <= w_upd_tmask;
            r_upd_pc_valid <= w_upd_pc_valid;
            r_upd_pc       <= w_upd_pc;
            r_err_ovf      <= r_err_ovf | w_set_ovf;
            r_err_unf      <= r_err_unf | w_set_unf;
        end
    end

    assign bus.req_ready_o    = (r_state == S_IDLE);
    assign bus.stk_push_o     = w_push;
    assign bus.stk_pop_o      = w_pop;
    assign bus.stk_pair_o     = w_pair;
    assign bus.stk_q1_o       = w_q1;
    assign bus.stk_q2_o       = w_q2;
    assign bus.upd_valid_o    = (r_state == S_RESP);
    assign bus.upd_tmask_o    = r_upd_tmask;
    assign bus.upd_pc_valid_o = r_upd_pc_valid;
    assign bus.upd_pc_o       = r_upd_pc;
    assign bus.err_ovf_o      = r_err_ovf;
    assign bus.err_unf_o      = r_err_unf;
endmodule
